seg7_scan_driver: RTL

Parametrised, time-multiplexed driver for a DIGITS-wide common-segment 7-segment display with per-digit decimal points. It takes a packed vector of nibbles plus decimal-point flags, double-buffers them so a frame is never torn, and scans digits one at a time with a configurable on-time and an inter-digit dark gap that suppresses ghosting. It sits between the counter/datapath logic and the board's segment and anode pins, replacing a per-digit combinational decoder.

---
 rtl/seg7_pkg.sv | 61 ++++++
 rtl/seg7_decode.sv | 23 ++
 rtl/seg7_scan_driver.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan driver:
//   - segment patterns {a,b,c,d,e,f,g} (bit 6 = a) for codes 0-F and a dash
//   - scan FSM state encoding (GAP = all dark, SHOW = one digit lit)
//   - seg7_pattern(): nibble -> segment pattern helper used by seg7_decode
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [0:0] {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_A    = 7'b1110111;
    localparam logic [6:0] SEG_B    = 7'b0011111;
    localparam logic [6:0] SEG_C    = 7'b1001110;
    localparam logic [6:0] SEG_D    = 7'b0111101;
    localparam logic [6:0] SEG_E    = 7'b1001111;
    localparam logic [6:0] SEG_F    = 7'b1000111;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Nibble to segment pattern. Codes 10-15 render as hex letters when
    // hex_mode is set, otherwise as a dash to flag an out-of-range BCD code.
    function automatic logic [6:0] seg7_pattern(input logic [3:0] code,
                                                input logic       hex_mode);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = hex_mode ? SEG_A : SEG_DASH;
            4'hB:    pat = hex_mode ? SEG_B : SEG_DASH;
            4'hC:    pat = hex_mode ? SEG_C : SEG_DASH;
            4'hD:    pat = hex_mode ? SEG_D : SEG_DASH;
            4'hE:    pat = hex_mode ? SEG_E : SEG_DASH;
            4'hF:    pat = hex_mode ? SEG_F : SEG_DASH;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational nibble -> 7-segment pattern decoder.
//   HEX_MODE : 1 = codes 10-15 show A b C d E F, 0 = codes 10-15 show a dash
// Ports:
//   code    in  4  digit code
//   pattern out 7  segments {a,b,c,d,e,f,g}, active-high
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    // Pure table lookup; no state.
    always_comb begin
        pattern = seg7_pattern(code, (HEX_MODE != 0));
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a DIGITS-wide common-segment 7-segment display.
// Incoming digits are captured into a pending buffer and promoted to the
// display buffer only at a frame boundary (entry to SHOW of digit 0), so a
// frame is never torn. Each digit slot is GAP_CYCLES dark cycles followed by
// SCAN_DIV lit cycles.
//
// Parameters: DIGITS (1..8), SCAN_DIV (>=1), GAP_CYCLES (>=0), HEX_MODE (0/1)
// Build option: define SEG7_LZB_EN for leading-zero blanking (digit k>0 is
//   blanked when it and every higher digit have code 0 and dp 0; an and dp
//   are still driven; digit 0 is never blanked).
//
// Ports:
//   clk          in   1         system clock, rising edge
//   rst          in   1         asynchronous active-high reset
//   bcd_in       in   4*DIGITS  digit k = bcd_in[4k+3:4k], digit 0 rightmost
//   dp_in        in   DIGITS    decimal point per digit
//   load         in   1         capture strobe for bcd_in/dp_in
//   seg          out  7         {a..g}, seg[6]=a, active-high
//   dp           out  1         decimal point of lit digit
//   an           out  DIGITS    one-hot digit enable, zero during gap
//   frame_start  out  1         pulse on first SHOW cycle of digit 0
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GAP_CYCLES = 16,
    parameter int HEX_MODE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : {CW{1'b0}};
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

    // Scan FSM
    scan_state_e              state_r, state_next_s;
    logic [CW-1:0]            cnt_r, cnt_next_s;
    logic [DW-1:0]            digit_r, digit_next_s;
    logic                     enter_show_s;
    logic                     frame_edge_s;

    // Double buffer
    logic [4*DIGITS-1:0]      disp_bcd_r, disp_bcd_next_s;
    logic [DIGITS-1:0]        disp_dp_r, disp_dp_next_s;
    logic [4*DIGITS-1:0]      pend_bcd_r, pend_bcd_next_s;
    logic [DIGITS-1:0]        pend_dp_r, pend_dp_next_s;
    logic                     pend_valid_r, pend_valid_next_s;

    // Digit selection / decode
    logic [DIGITS-1:0]        lead_zero_s;
    logic [DIGITS-1:0]        an_next_s;
    logic [3:0]               cur_code_s;
    logic                     cur_dp_s;
    logic                     cur_blank_s;
    logic [6:0]               cur_pattern_s;

    // Output registers
    logic [6:0]               seg_r;
    logic                     dp_r;
    logic [DIGITS-1:0]        an_r;
    logic                     frame_start_r;

    // FSM state, slot counter and digit index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_GAP;
            cnt_r   <= {CW{1'b0}};
            digit_r <= {DW{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            digit_r <= digit_next_s;
        end
    end

    // Next-state logic. enter_show_s marks the edge on which a digit lights,
    // which is also where the display buffer may be refreshed for digit 0.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        digit_next_s = digit_r;
        enter_show_s = 1'b0;
        case (state_r)
            ST_GAP: begin
                if ((GAP_CYCLES == 0) || (cnt_r == GAP_LAST)) begin
                    state_next_s = ST_SHOW;
                    cnt_next_s   = {CW{1'b0}};
                    enter_show_s = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CW'(1'b1);
                end
            end
            ST_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    cnt_next_s   = {CW{1'b0}};
                    digit_next_s = (digit_r == DIGIT_LAST) ? {DW{1'b0}} : (digit_r + DW'(1'b1));
                    if (GAP_CYCLES == 0) begin
                        // No dark gap: go straight to lighting the next digit.
                        state_next_s = ST_SHOW;
                        enter_show_s = 1'b1;
                    end else begin
                        state_next_s = ST_GAP;
                    end
                end else begin
                    cnt_next_s   = cnt_r + CW'(1'b1);
                end
            end
            default: begin
                state_next_s = ST_GAP;
                cnt_next_s   = {CW{1'b0}};
                digit_next_s = {DW{1'b0}};
            end
        endcase
    end

    assign frame_edge_s = enter_show_s && (digit_next_s == {DW{1'b0}});

    // Buffer update. At a frame edge a coincident load bypasses the pending
    // buffer so the new frame shows the freshest data; otherwise a pending
    // frame is promoted. Between edges a load only refreshes the pending copy.
    always_comb begin
        disp_bcd_next_s   = disp_bcd_r;
        disp_dp_next_s    = disp_dp_r;
        pend_bcd_next_s   = pend_bcd_r;
        pend_dp_next_s    = pend_dp_r;
        pend_valid_next_s = pend_valid_r;
        if (frame_edge_s) begin
            if (load) begin
                disp_bcd_next_s   = bcd_in;
                disp_dp_next_s    = dp_in;
                pend_valid_next_s = 1'b0;
            end else if (pend_valid_r) begin
                disp_bcd_next_s   = pend_bcd_r;
                disp_dp_next_s    = pend_dp_r;
                pend_valid_next_s = 1'b0;
            end else begin
                pend_valid_next_s = 1'b0;
            end
        end else if (load) begin
            pend_bcd_next_s   = bcd_in;
            pend_dp_next_s    = dp_in;
            pend_valid_next_s = 1'b1;
        end else begin
            pend_valid_next_s = pend_valid_r;
        end
    end

    // Display and pending buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_bcd_r   <= {(4*DIGITS){1'b0}};
            disp_dp_r    <= {DIGITS{1'b0}};
            pend_bcd_r   <= {(4*DIGITS){1'b0}};
            pend_dp_r    <= {DIGITS{1'b0}};
            pend_valid_r <= 1'b0;
        end else begin
            disp_bcd_r   <= disp_bcd_next_s;
            disp_dp_r    <= disp_dp_next_s;
            pend_bcd_r   <= pend_bcd_next_s;
            pend_dp_r    <= pend_dp_next_s;
            pend_valid_r <= pend_valid_next_s;
        end
    end

`ifdef SEG7_LZB_EN
    // Leading-zero map: walk from the most significant digit down; a digit is
    // blankable while it and everything above it is code 0 with dp clear.
    // Uses the next display buffer so the first lit cycle of a new frame is
    // already consistent with the data being shown.
    always_comb begin
        logic run_v;
        run_v       = 1'b1;
        lead_zero_s = {DIGITS{1'b0}};
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run_v          = run_v && (disp_bcd_next_s[4*k +: 4] == 4'h0) && !disp_dp_next_s[k];
            lead_zero_s[k] = run_v;
        end
        lead_zero_s[0] = 1'b0;
    end
`else
    // Blanking disabled: every digit is always decoded.
    always_comb begin
        lead_zero_s = {DIGITS{1'b0}};
    end
`endif

    // Select the digit that will be lit after this edge; an one-hot follows it.
    always_comb begin
        cur_code_s  = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        an_next_s   = {DIGITS{1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_next_s == DW'(k)) begin
                cur_code_s   = disp_bcd_next_s[4*k +: 4];
                cur_dp_s     = disp_dp_next_s[k];
                cur_blank_s  = lead_zero_s[k];
                an_next_s[k] = 1'b1;
            end else begin
                an_next_s[k] = 1'b0;
            end
        end
    end

    seg7_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_decode (
        .code    (cur_code_s),
        .pattern (cur_pattern_s)
    );

    // Output registers, loaded from next-state values so pins change on the
    // same edge the FSM enters GAP or SHOW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r         <= SEG_OFF;
            dp_r          <= 1'b0;
            an_r          <= {DIGITS{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            if (state_next_s == ST_SHOW) begin
                an_r  <= an_next_s;
                seg_r <= cur_blank_s ? SEG_OFF : cur_pattern_s;
                dp_r  <= cur_dp_s;
            end else begin
                an_r  <= {DIGITS{1'b0}};
                seg_r <= SEG_OFF;
                dp_r  <= 1'b0;
            end
            frame_start_r <= frame_edge_s;
        end
    end

    assign seg         = seg_r;
    assign dp          = dp_r;
    assign an          = an_r;
    assign frame_start = frame_start_r;

endmodule
